// File: rtl/ble6_cfg_pkg.sv
// Shared types and sizing helpers for the ble6 configuration bank loader.
package ble6_cfg_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_WRITE,
    ST_HOLD,
    ST_DONE,
    ST_ERR
  } state_e;

  localparam int BLE6_CFG_BITS = 66;
  localparam int BLE6_LUT_BITS = 64;

  // Words needed to cover a frame of the given bit count.
  function automatic int nwords(input int bits, input int w);
    return (bits + w - 1) / w;
  endfunction

endpackage

// File: rtl/ble6_cfg_pulse_timer.sv
// Reloadable down-counter; flags the last cycle of a programmed duration.
module ble6_cfg_pulse_timer #(
  parameter int W = 2
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  output logic         expired_o
);

  logic [W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = load_val_i;
    end else if (count_q != '0) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  // A load of N yields exactly N cycles before expiry is seen by the FSM.
  assign expired_o = (count_q == W'(1));

endmodule

// File: rtl/ble6_cfg_bank_loader.sv
// Streams a ble6 configuration frame into a staging register, then drives
// one timed bl/wl write pulse into the tile's configuration cells.
module ble6_cfg_bank_loader
  import ble6_cfg_pkg::*;
#(
  parameter int NUM_BITS = BLE6_CFG_BITS,
  parameter int WORD_W   = 8,
  parameter int WL_PULSE = 2,
  parameter int BL_HOLD  = 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic                cfg_valid,
  output logic                cfg_ready,
  input  logic [WORD_W-1:0]   cfg_data,
  input  logic                cfg_last,
  output logic [NUM_BITS-1:0] bl,
  output logic [NUM_BITS-1:0] wl,
  output logic                busy,
  output logic                done,
  output logic                err
);

  localparam int NWORDS    = nwords(NUM_BITS, WORD_W);
  localparam int CNT_W     = $clog2(NWORDS + 1);
  localparam int MAX_PULSE = (WL_PULSE > BL_HOLD) ? WL_PULSE : BL_HOLD;
  localparam int TMR_W     = $clog2(MAX_PULSE + 1);

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [NUM_BITS-1:0]  stage_q, stage_d;
  logic                 err_q, err_d;
  logic                 tmr_load;
  logic [TMR_W-1:0]     tmr_val;
  logic                 tmr_expired;
  logic                 xfer;
  logic                 last_word;
  logic [NUM_BITS-1:0]  fill_bits;
  logic [NUM_BITS-1:0]  fill_sel;

  assign xfer      = cfg_valid && (state_q == ST_LOAD);
  assign last_word = (cnt_q == CNT_W'(NWORDS - 1));

  // Cell g is owned by word g/WORD_W; cells past NUM_BITS simply do not exist.
  for (genvar g = 0; g < NUM_BITS; g++) begin : g_fill
    assign fill_bits[g] = cfg_data[g % WORD_W];
    assign fill_sel[g]  = (cnt_q == CNT_W'(g / WORD_W));
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    stage_d  = stage_q;
    err_d    = err_q;
    tmr_load = 1'b0;
    tmr_val  = '0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_LOAD;
          cnt_d   = '0;
          err_d   = 1'b0;
        end
      end
      ST_LOAD: begin
        if (xfer) begin
          stage_d = (stage_q & ~fill_sel) | (fill_bits & fill_sel);
          if (cfg_last && last_word) begin
            state_d  = ST_WRITE;
            tmr_load = 1'b1;
            tmr_val  = TMR_W'(WL_PULSE);
          end else if (cfg_last || last_word) begin
            state_d = ST_ERR;
            err_d   = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      ST_WRITE: begin
        if (tmr_expired) begin
          state_d  = ST_HOLD;
          tmr_load = 1'b1;
          tmr_val  = TMR_W'(BL_HOLD);
        end
      end
      ST_HOLD: begin
        if (tmr_expired) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      ST_ERR:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      stage_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      stage_q <= stage_d;
      err_q   <= err_d;
    end
  end

  ble6_cfg_pulse_timer #(
    .W(TMR_W)
  ) u_timer (
    .clk_i      (clk),
    .rst_ni     (reset),
    .load_i     (tmr_load),
    .load_val_i (tmr_val),
    .expired_o  (tmr_expired)
  );

  // Decoded straight from state so an async reset kills wl and bl at once.
  assign bl        = (state_q == ST_WRITE || state_q == ST_HOLD) ? stage_q : '0;
  assign wl        = (state_q == ST_WRITE) ? '1 : '0;
  assign cfg_ready = (state_q == ST_LOAD);
  assign busy      = (state_q == ST_LOAD) || (state_q == ST_WRITE) || (state_q == ST_HOLD);
  assign done      = (state_q == ST_DONE);
  assign err       = err_q;

endmodule

// File: tb/tb_ble6_cfg_bank_loader.sv
// Scoreboard bench for the ble6 configuration bank loader.
module tb_ble6_cfg_bank_loader;

  logic        clk = 1'b0;
  logic        reset = 1'b0;

  logic        start = 1'b0;
  logic        cfg_valid = 1'b0;
  logic [7:0]  cfg_data = '0;
  logic        cfg_last = 1'b0;
  logic        cfg_ready;
  logic [65:0] bl, wl;
  logic        busy, done, err;

  logic        start2 = 1'b0;
  logic        valid2 = 1'b0;
  logic [31:0] data2 = '0;
  logic        last2 = 1'b0;
  logic        ready2;
  logic [65:0] bl2, wl2;
  logic        busy2, done2, err2;

  int testsRun = 0;
  int testsFailed = 0;

  typedef struct {
    bit          isErr;
    logic [65:0] blExp;
    int          wlCycles;
    int          holdCycles;
  } exp_t;

  exp_t expQ[$];
  exp_t monE;

  localparam logic [65:0] GOOD_BL  = {2'b11, 64'h0807060504030201};
  localparam logic [65:0] SWEEP_BL = {2'b10, 64'h0807060504030201};

  logic [7:0] frameWords [9];

  always #5 clk = ~clk;

  ble6_cfg_bank_loader dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .cfg_data  (cfg_data),
    .cfg_last  (cfg_last),
    .bl        (bl),
    .wl        (wl),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  ble6_cfg_bank_loader #(
    .NUM_BITS (66),
    .WORD_W   (32),
    .WL_PULSE (4),
    .BL_HOLD  (1)
  ) dutWide (
    .clk       (clk),
    .reset     (reset),
    .start     (start2),
    .cfg_valid (valid2),
    .cfg_ready (ready2),
    .cfg_data  (data2),
    .cfg_last  (last2),
    .bl        (bl2),
    .wl        (wl2),
    .busy      (busy2),
    .done      (done2),
    .err       (err2)
  );

  task automatic checkOutput(input string name, input logic [65:0] act, input logic [65:0] expv);
    testsRun++;
    if (act !== expv) begin
      testsFailed++;
      $display("[TB] FAIL %s: actual=%0h required=%0h", name, act, expv);
    end
  endtask

  // Monitor: measures each write pulse and compares against the scoreboard
  // whenever the DUT reports done or raises err.
  int          wlRun = 0;
  int          holdRun = 0;
  logic        errPrev = 1'b0;
  logic [65:0] blAtWl = '0;

  always @(negedge clk) begin
    if (!reset) begin
      wlRun   = 0;
      holdRun = 0;
      errPrev = 1'b0;
    end else begin
      if (wl != '0) begin
        if (wlRun == 0) blAtWl = bl;
        checkOutput("wl_all_ones", wl, {66{1'b1}});
        wlRun++;
      end else if (wlRun > 0 && !done) begin
        holdRun++;
      end
      if (done) begin
        if (expQ.size() == 0) begin
          checkOutput("unexpected_done", 66'(1), 66'(0));
        end else begin
          monE = expQ.pop_front();
          checkOutput("event_kind_done", 66'(0), 66'(monE.isErr));
          checkOutput("bl_at_wl", blAtWl, monE.blExp);
          checkOutput("wl_cycles", 66'(wlRun), 66'(monE.wlCycles));
          checkOutput("hold_cycles", 66'(holdRun), 66'(monE.holdCycles));
          checkOutput("busy_with_done", 66'(busy), 66'(0));
          checkOutput("bl_in_done", bl, 66'(0));
        end
        wlRun   = 0;
        holdRun = 0;
      end
      if (err && !errPrev) begin
        if (expQ.size() == 0) begin
          checkOutput("unexpected_err", 66'(1), 66'(0));
        end else begin
          monE = expQ.pop_front();
          checkOutput("event_kind_err", 66'(1), 66'(monE.isErr));
          checkOutput("wl_before_err", 66'(wlRun), 66'(0));
          checkOutput("busy_with_err", 66'(busy), 66'(0));
        end
        wlRun   = 0;
        holdRun = 0;
      end
      errPrev = err;
    end
  end

  // All stimulus tasks start and end at 1 time unit after a rising edge.
  task automatic applyStimulus(input logic [7:0] d, input logic last);
    bit got = 1'b0;
    cfg_valid = 1'b1;
    cfg_data  = d;
    cfg_last  = last;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (cfg_ready) begin
        got = 1'b1;
        break;
      end
    end
    checkOutput("handshake", 66'(got), 66'(1));
    if (got) begin
      @(posedge clk);
      #1;
    end
    cfg_valid = 1'b0;
    cfg_last  = 1'b0;
    cfg_data  = '0;
  endtask

  task automatic doStart();
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    checkOutput("busy_after_start", 66'(busy), 66'(1));
    checkOutput("err_after_start", 66'(err), 66'(0));
    checkOutput("ready_in_load", 66'(cfg_ready), 66'(1));
  endtask

  task automatic sendFrame(input int nSend, input int lastAt, input bit gaps);
    for (int i = 0; i < nSend; i++) begin
      applyStimulus(frameWords[i], i == lastAt);
      if (gaps && i != nSend - 1) begin
        repeat (3) begin
          @(negedge clk);
          checkOutput("ready_in_gap", 66'(cfg_ready), 66'(1));
          @(posedge clk);
          #1;
        end
      end
    end
  endtask

  task automatic waitIdle();
    bit idle = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (!busy) begin
        idle = 1'b1;
        break;
      end
    end
    checkOutput("idle_reached", 66'(idle), 66'(1));
    @(posedge clk);
    #1;
    checkOutput("done_single_pulse", 66'(done), 66'(0));
    checkOutput("wl_idle", wl, 66'(0));
  endtask

  task automatic applyStimulus2(input logic [31:0] d, input logic last);
    bit got = 1'b0;
    valid2 = 1'b1;
    data2  = d;
    last2  = last;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (ready2) begin
        got = 1'b1;
        break;
      end
    end
    checkOutput("wide_handshake", 66'(got), 66'(1));
    if (got) begin
      @(posedge clk);
      #1;
    end
    valid2 = 1'b0;
    last2  = 1'b0;
    data2  = '0;
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not complete in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int          wlCnt;
    bit          doneSeen;
    logic [65:0] blCap;

    frameWords = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'h03};

    #2;
    checkOutput("reset_bl", bl, 66'(0));
    checkOutput("reset_wl", wl, 66'(0));
    checkOutput("reset_ready", 66'(cfg_ready), 66'(0));
    checkOutput("reset_busy", 66'(busy), 66'(0));
    checkOutput("reset_done", 66'(done), 66'(0));
    checkOutput("reset_err", 66'(err), 66'(0));
    checkOutput("reset_wide_wl", wl2, 66'(0));
    #10;
    reset = 1'b1;
    @(posedge clk);
    #1;

    $display("[TB] nominal frame");
    expQ.push_back('{isErr: 1'b0, blExp: GOOD_BL, wlCycles: 2, holdCycles: 1});
    doStart();
    sendFrame(9, 8, 1'b0);
    waitIdle();

    $display("[TB] frame with gaps");
    expQ.push_back('{isErr: 1'b0, blExp: GOOD_BL, wlCycles: 2, holdCycles: 1});
    doStart();
    sendFrame(9, 8, 1'b1);
    waitIdle();

    $display("[TB] short frame then recovery");
    expQ.push_back('{isErr: 1'b1, blExp: '0, wlCycles: 0, holdCycles: 0});
    doStart();
    sendFrame(5, 4, 1'b0);
    waitIdle();
    checkOutput("err_sticky", 66'(err), 66'(1));
    expQ.push_back('{isErr: 1'b0, blExp: GOOD_BL, wlCycles: 2, holdCycles: 1});
    doStart();
    sendFrame(9, 8, 1'b0);
    waitIdle();

    $display("[TB] long frame");
    expQ.push_back('{isErr: 1'b1, blExp: '0, wlCycles: 0, holdCycles: 0});
    doStart();
    sendFrame(9, -1, 1'b0);
    cfg_valid = 1'b1;
    cfg_data  = 8'hAA;
    repeat (2) begin
      @(negedge clk);
      checkOutput("ready_tenth_word", 66'(cfg_ready), 66'(0));
      @(posedge clk);
      #1;
    end
    cfg_valid = 1'b0;
    cfg_data  = '0;
    checkOutput("err_after_long", 66'(err), 66'(1));
    checkOutput("busy_after_long", 66'(busy), 66'(0));

    $display("[TB] reset during write");
    doStart();
    sendFrame(9, 8, 1'b0);
    checkOutput("wl_in_write", wl, {66{1'b1}});
    checkOutput("bl_in_write", bl, GOOD_BL);
    reset = 1'b0;
    #1;
    checkOutput("wl_async_reset", wl, 66'(0));
    checkOutput("bl_async_reset", bl, 66'(0));
    checkOutput("busy_async_reset", 66'(busy), 66'(0));
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    expQ.push_back('{isErr: 1'b0, blExp: GOOD_BL, wlCycles: 2, holdCycles: 1});
    doStart();
    sendFrame(9, 8, 1'b0);
    waitIdle();

    $display("[TB] 32-bit word variant");
    start2 = 1'b1;
    @(posedge clk);
    #1;
    start2 = 1'b0;
    checkOutput("wide_busy", 66'(busy2), 66'(1));
    applyStimulus2(32'h04030201, 1'b0);
    applyStimulus2(32'h08070605, 1'b0);
    applyStimulus2(32'hABCDEF02, 1'b1);
    wlCnt    = 0;
    doneSeen = 1'b0;
    blCap    = '0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (wl2 != '0) begin
        if (wlCnt == 0) blCap = bl2;
        wlCnt++;
      end
      if (done2) begin
        doneSeen = 1'b1;
        break;
      end
    end
    checkOutput("wide_wl_cycles", 66'(wlCnt), 66'(4));
    checkOutput("wide_bl", blCap, SWEEP_BL);
    checkOutput("wide_done", 66'(doneSeen), 66'(1));
    checkOutput("wide_err", 66'(err2), 66'(0));
    @(posedge clk);
    #1;

    repeat (3) @(posedge clk);
    #1;
    checkOutput("scoreboard_drained", 66'(expQ.size()), 66'(0));

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
